// File: rtl/mem_resp_pkg.sv
// Shared widths, base address and FSM encodings for the load/store memory responder.
package mem_resp_pkg;

    localparam int unsigned XLEN_BUS_W = 64;
    localparam int unsigned MASK_BUS_W = XLEN_BUS_W / 8;
    localparam int unsigned RAM_BUS_W  = 12;
    localparam int unsigned ADDR_BUS_W = 32;
    localparam int unsigned CNT_W      = 4;

    localparam logic [31:0] MEM_BASE = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_resp_if.sv
// Request/response bus between the core LSU (master) and the memory responder (slave).
interface mem_resp_if
    import mem_resp_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_BUS_W,
    parameter int unsigned AW   = ADDR_BUS_W
);
    localparam int unsigned MW = XLEN / 8;

    logic            req_valid_i;
    logic            req_ready_o;
    logic            req_wen_i;
    logic [AW-1:0]   req_addr_i;
    logic [XLEN-1:0] req_wdata_i;
    logic [MW-1:0]   req_wmask_i;
    logic            resp_valid_o;
    logic            resp_ready_i;
    logic [XLEN-1:0] resp_rdata_o;
    logic            resp_err_o;

    modport master (
        output req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_wmask_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

    modport slave (
        input  req_valid_i, req_wen_i, req_addr_i, req_wdata_i, req_wmask_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
    );

endinterface

// File: rtl/mem_sram_array.sv
// Byte-enabled synchronous word storage; read data is registered on the access edge.
module mem_sram_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned XLEN       = XLEN_BUS_W,
    parameter int unsigned DEPTH_LOG2 = RAM_BUS_W
) (
    input  logic                  clk_i,
    input  logic                  en,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [XLEN-1:0]       wdata,
    input  logic [XLEN/8-1:0]     wmask,
    output logic [XLEN-1:0]       rdata
);
    localparam int unsigned MW    = XLEN / 8;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [XLEN-1:0] mem [DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < MW; i++) begin
                    if (wmask[i]) begin
                        mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/mem_resp.sv
// Multi-cycle memory responder for the core's load/store port: latches a request,
// waits LATENCY cycles, performs the range-checked access and holds the response.
module mem_resp
    import mem_resp_pkg::*;
#(
    parameter int unsigned   XLEN       = XLEN_BUS_W,
    parameter int unsigned   AW         = ADDR_BUS_W,
    parameter int unsigned   DEPTH_LOG2 = RAM_BUS_W,
    parameter logic [AW-1:0] BASE       = AW'(MEM_BASE),
    parameter int unsigned   LATENCY    = 1
) (
    input  logic     clk_i,
    input  logic     rst_i,
    mem_resp_if.slave bus
);
    localparam int unsigned MW    = XLEN / 8;
    localparam int unsigned OFF_W = DEPTH_LOG2 + 3;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wen_q, wen_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [MW-1:0]     wmask_q, wmask_d;
    logic              ready_q, ready_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              rdsel_q, rdsel_d;
    logic              access;

    logic [AW-1:0]         offset;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [XLEN-1:0]       sram_rdata;
    logic                  unused_off;

    // Range check on the latched address; low three bits select a byte lane only.
    assign offset     = addr_q - BASE;
    assign in_range   = (addr_q >= BASE) && (offset[AW-1:OFF_W] == '0);
    assign idx        = offset[OFF_W-1:3];
    assign unused_off = ^offset[2:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rdsel_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            rdsel_q <= rdsel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        ready_d = ready_q;
        valid_d = valid_q;
        err_d   = err_q;
        rdsel_d = rdsel_q;
        access  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req_valid_i && ready_q) begin
                    wen_d   = bus.req_wen_i;
                    addr_d  = bus.req_addr_i;
                    wdata_d = bus.req_wdata_i;
                    wmask_d = bus.req_wmask_i;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    ready_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    access  = 1'b1;
                    err_d   = !in_range;
                    rdsel_d = in_range && !wen_q;
                    valid_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready_i) begin
                    valid_d = 1'b0;
                    err_d   = 1'b0;
                    rdsel_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    mem_sram_array #(
        .XLEN       (XLEN),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_sram (
        .clk_i (clk_i),
        .en    (access && in_range),
        .we    (wen_q),
        .idx   (idx),
        .wdata (wdata_q),
        .wmask (wmask_q),
        .rdata (sram_rdata)
    );

    assign bus.req_ready_o  = ready_q;
    assign bus.resp_valid_o = valid_q;
    assign bus.resp_err_o   = err_q;
    assign bus.resp_rdata_o = rdsel_q ? sram_rdata : '0;

endmodule

// File: tb/tb_mem_resp.sv
// Directed bench for mem_resp: one instance at LATENCY=1, one at LATENCY=4.
module tb_mem_resp;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  mask;
        logic [63:0] exp_rdata;
        logic        exp_err;
        string       name;
    } vec_t;

    logic clk;
    logic rst_n [2];

    logic        req_valid  [2];
    logic        req_wen    [2];
    logic [31:0] req_addr   [2];
    logic [63:0] req_wdata  [2];
    logic [7:0]  req_wmask  [2];
    logic        resp_ready [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic [63:0] resp_rdata [2];
    logic        resp_err   [2];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mem_resp_if #(.XLEN(64), .AW(32)) bus0 ();
    mem_resp_if #(.XLEN(64), .AW(32)) bus1 ();

    assign bus0.req_valid_i  = req_valid[0];
    assign bus0.req_wen_i    = req_wen[0];
    assign bus0.req_addr_i   = req_addr[0];
    assign bus0.req_wdata_i  = req_wdata[0];
    assign bus0.req_wmask_i  = req_wmask[0];
    assign bus0.resp_ready_i = resp_ready[0];
    assign req_ready[0]      = bus0.req_ready_o;
    assign resp_valid[0]     = bus0.resp_valid_o;
    assign resp_rdata[0]     = bus0.resp_rdata_o;
    assign resp_err[0]       = bus0.resp_err_o;

    assign bus1.req_valid_i  = req_valid[1];
    assign bus1.req_wen_i    = req_wen[1];
    assign bus1.req_addr_i   = req_addr[1];
    assign bus1.req_wdata_i  = req_wdata[1];
    assign bus1.req_wmask_i  = req_wmask[1];
    assign bus1.resp_ready_i = resp_ready[1];
    assign req_ready[1]      = bus1.req_ready_o;
    assign resp_valid[1]     = bus1.resp_valid_o;
    assign resp_rdata[1]     = bus1.resp_rdata_o;
    assign resp_err[1]       = bus1.resp_err_o;

    mem_resp #(.XLEN(64), .AW(32), .DEPTH_LOG2(12), .BASE(32'h8000_0000), .LATENCY(1)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n[0]),
        .bus   (bus0)
    );

    mem_resp #(.XLEN(64), .AW(32), .DEPTH_LOG2(12), .BASE(32'h8000_0000), .LATENCY(4)) dut1 (
        .clk_i (clk),
        .rst_i (rst_n[1]),
        .bus   (bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wen, input logic [31:0] addr, input logic [63:0] wdata,
                                input logic [7:0] mask, input logic [63:0] exp_rdata,
                                input logic exp_err, input string name);
        vec_t v;
        v.wen = wen; v.addr = addr; v.wdata = wdata; v.mask = mask;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.name = name;
        return v;
    endfunction

    // One full transaction: accept, latency, optional response stall, handshake.
    task automatic txn(input int d, input vec_t v, input int lat, input int stall);
        int n;
        req_wen[d]    = v.wen;
        req_addr[d]   = v.addr;
        req_wdata[d]  = v.wdata;
        req_wmask[d]  = v.mask;
        req_valid[d]  = 1'b1;
        resp_ready[d] = (stall == 0);
        n = 0;
        while (!req_ready[d] && n < 20) begin
            step();
            n++;
        end
        if (!req_ready[d]) begin
            chk({v.name, "_accept_timeout"}, 64'(req_ready[d]), 64'd1);
            req_valid[d] = 1'b0;
            return;
        end
        step();
        req_valid[d] = 1'b0;
        req_addr[d]  = 32'hFFFF_FFF0;
        req_wdata[d] = '1;
        req_wmask[d] = '1;
        n = 0;
        while (!resp_valid[d] && n < 40) begin
            step();
            n++;
        end
        chk({v.name, "_latency"}, 64'(n), 64'(lat));
        chk({v.name, "_rdata"}, resp_rdata[d], v.exp_rdata);
        chk({v.name, "_err"}, 64'(resp_err[d]), 64'(v.exp_err));
        chk({v.name, "_busy"}, 64'(req_ready[d]), 64'd0);
        for (int s = 0; s < stall; s++) begin
            step();
            chk({v.name, "_stall_valid"}, 64'(resp_valid[d]), 64'd1);
            chk({v.name, "_stall_rdata"}, resp_rdata[d], v.exp_rdata);
            chk({v.name, "_stall_err"}, 64'(resp_err[d]), 64'(v.exp_err));
            chk({v.name, "_stall_ready"}, 64'(req_ready[d]), 64'd0);
        end
        resp_ready[d] = 1'b1;
        step();
        chk({v.name, "_drop_valid"}, 64'(resp_valid[d]), 64'd0);
        chk({v.name, "_ready_back"}, 64'(req_ready[d]), 64'd1);
        resp_ready[d] = 1'b0;
    endtask

    vec_t        tbl [14];
    logic [31:0] b2b_addr [3];
    logic [63:0] b2b_exp  [3];
    int          acc_at   [3];
    int          resp_at  [3];
    int          nacc, nresp;

    initial begin
        tbl[0]  = mk(1'b1, 32'h8000_0010, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0, "st_full");
        tbl[1]  = mk(1'b0, 32'h8000_0010, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, "ld_full");
        tbl[2]  = mk(1'b1, 32'h8000_0010, 64'hAAAAAAAABBBBBBBB, 8'h0F, 64'h0, 1'b0, "st_part");
        tbl[3]  = mk(1'b0, 32'h8000_0010, 64'h0, 8'h00, 64'h11223344BBBBBBBB, 1'b0, "ld_part");
        tbl[4]  = mk(1'b1, 32'h8000_0000, 64'h0102030405060708, 8'hFF, 64'h0, 1'b0, "st_w0");
        tbl[5]  = mk(1'b0, 32'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1, "ld_below");
        tbl[6]  = mk(1'b0, 32'h8000_8000, 64'h0, 8'h00, 64'h0, 1'b1, "ld_above");
        tbl[7]  = mk(1'b1, 32'h8000_8000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1, "st_above");
        tbl[8]  = mk(1'b0, 32'h8000_0000, 64'h0, 8'h00, 64'h0102030405060708, 1'b0, "ld_w0");
        tbl[9]  = mk(1'b1, 32'h8000_0010, 64'hDEADBEEFDEADBEEF, 8'h00, 64'h0, 1'b0, "st_mask0");
        tbl[10] = mk(1'b0, 32'h8000_0014, 64'h0, 8'h00, 64'h11223344BBBBBBBB, 1'b0, "ld_mask0");
        tbl[11] = mk(1'b1, 32'h8000_7FF8, 64'hCAFEF00D12345678, 8'hFF, 64'h0, 1'b0, "st_top");
        tbl[12] = mk(1'b1, 32'h8000_7FF8, 64'h0, 8'h81, 64'h0, 1'b0, "st_top_edges");
        tbl[13] = mk(1'b0, 32'h8000_7FFF, 64'h0, 8'h00, 64'h00FEF00D12345600, 1'b0, "ld_top");

        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; req_valid[d] = 1'b0; req_wen[d] = 1'b0; req_addr[d] = '0;
            req_wdata[d] = '0; req_wmask[d] = '0; resp_ready[d] = 1'b0;
        end
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", 64'(req_ready[d]), 64'd1);
            chk("rst_valid", 64'(resp_valid[d]), 64'd0);
            chk("rst_rdata", resp_rdata[d], 64'd0);
            chk("rst_err", 64'(resp_err[d]), 64'd0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            txn(0, tbl[i], 1, 0);
        end

        // Back-to-back loads with req_valid held high and resp_ready held high.
        b2b_addr[0] = 32'h8000_0010; b2b_exp[0] = 64'h11223344BBBBBBBB;
        b2b_addr[1] = 32'h8000_0000; b2b_exp[1] = 64'h0102030405060708;
        b2b_addr[2] = 32'h8000_7FF8; b2b_exp[2] = 64'h00FEF00D12345600;
        for (int i = 0; i < 3; i++) begin
            acc_at[i] = 0;
            resp_at[i] = 0;
        end
        nacc = 0; nresp = 0;
        req_wen[0] = 1'b0; req_valid[0] = 1'b1; resp_ready[0] = 1'b1;
        for (int t = 0; t < 40 && nresp < 3; t++) begin
            if (nacc < 3) req_addr[0] = b2b_addr[nacc];
            else          req_valid[0] = 1'b0;
            if (resp_valid[0]) begin
                chk($sformatf("b2b_rdata%0d", nresp), resp_rdata[0], b2b_exp[nresp]);
                resp_at[nresp] = cyc;
                nresp++;
            end
            if (req_ready[0] && nacc < 3) begin
                acc_at[nacc] = cyc;
                nacc++;
            end
            step();
        end
        req_valid[0] = 1'b0;
        resp_ready[0] = 1'b0;
        chk("b2b_count", 64'(nresp), 64'd3);
        chk("b2b_gap01", 64'(acc_at[1] - acc_at[0]), 64'd3);
        chk("b2b_gap12", 64'(acc_at[2] - acc_at[1]), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("b2b_lat%0d", i), 64'(resp_at[i] - acc_at[i]), 64'd2);
        end

        // LATENCY=4 with a stalled response.
        txn(1, mk(1'b1, 32'h8000_0040, 64'h5555666677778888, 8'hFF, 64'h0, 1'b0, "l4_st"), 4, 0);
        txn(1, mk(1'b0, 32'h8000_0040, 64'h0, 8'h00, 64'h5555666677778888, 1'b0, "l4_ld_stall"), 4, 3);
        txn(1, mk(1'b0, 32'h8000_8008, 64'h0, 8'h00, 64'h0, 1'b1, "l4_err_stall"), 4, 2);

        // Reset during WAIT must abort a pending store.
        txn(1, mk(1'b1, 32'h8000_0020, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0, "pre_st"), 4, 0);
        req_wen[1] = 1'b1; req_addr[1] = 32'h8000_0020;
        req_wdata[1] = 64'hFFFF_0000_FFFF_0000; req_wmask[1] = 8'hFF;
        req_valid[1] = 1'b1;
        step();
        req_valid[1] = 1'b0;
        step();
        chk("abort_in_wait", 64'(req_ready[1]), 64'd0);
        rst_n[1] = 1'b0;
        #1;
        chk("abort_valid", 64'(resp_valid[1]), 64'd0);
        chk("abort_ready", 64'(req_ready[1]), 64'd1);
        step();
        step();
        step();
        @(negedge clk);
        rst_n[1] = 1'b1;
        step();
        txn(1, mk(1'b0, 32'h8000_0020, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0, "post_abort_ld"), 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Memory-side responder for the core's load/store port.
- The core's LSU acts as initiator, driving address, write data, byte mask and read/write enables; this block services those requests over a valid/ready handshake.
- It holds a byte-writable word array with programmable access latency and reports out-of-range accesses.
- It sits between the core's load/store path and the simulation top. It replaces the single-cycle combinational memory model, so the core can be exercised against multi-cycle memory.

Parameters:
- XLEN, 64, data word width in bits; mask width is XLEN/8.
- AW, 32, request address width.
- DEPTH_LOG2, 12, log2 of the number of XLEN words stored.
- BASE, 32'h8000_0000, first byte address mapped to word 0.
- LATENCY, 1, cycles from the accepting clock edge to resp_valid_o; legal range 1..15.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  responder can accept a request.
- req_wen_i  in  1  1 = store, 0 = load.
- req_addr_i  in  AW  byte address; bits [2:0] are ignored for indexing.
- req_wdata_i  in  XLEN  store data, lane-aligned.
- req_wmask_i  in  XLEN/8  byte strobes for stores.
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  initiator accepts the response.
- resp_rdata_o  out  XLEN  load data, full word.
- resp_err_o  out  1  access was out of range.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state goes to IDLE.
  - req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0, counter=0.
  - Array contents are not cleared.
  - Reset asserted in any state aborts the transaction in flight. A pending store that has not reached its access edge is not performed.
- FSM states and transitions:
  - IDLE: req_ready_o=1. On req_valid_i&&req_ready_o, latch wen/addr/wdata/wmask, load counter with LATENCY-1, go to WAIT.
  - WAIT: req_ready_o=0. If counter!=0, decrement. If counter==0, perform the access on this edge and go to RESP.
  - RESP: resp_valid_o=1. rdata and err stay stable until resp_valid_o&&resp_ready_i; on that handshake go to IDLE and drop resp_valid_o.
- Timing:
  - A request accepted at edge k produces resp_valid_o high after edge k+LATENCY.
  - No new request is accepted in the handshake cycle; req_ready_o rises after the edge that leaves RESP.
  - Minimum issue interval is LATENCY+2 cycles.
- Address check:
  - idx = (addr-BASE)>>3 (AW-bit subtraction).
  - In range iff addr>=BASE and (addr-BASE) < 2^(DEPTH_LOG2+3).
  - Out of range: resp_err_o=1, resp_rdata_o=0, array untouched.
- Load: resp_rdata_o = array[idx], i.e. the full word. Byte extraction and sign extension belong to the core.
- Store:
  - For each i with wmask[i]=1, byte i of array[idx] takes wdata byte i; other bytes are unchanged.
  - resp_rdata_o=0.
  - A mask of 0 still produces a response and leaves the array unchanged.
- Read-after-write: a load issued after a store's response handshake returns the stored bytes.
- Inputs are sampled only at the accept edge. Changes on the req_* inputs outside IDLE are ignored.
- resp_ready_i held high before resp_valid_o rises: the response is consumed in its first valid cycle.
- req_valid_i may stay high across transactions; each accept consumes exactly one request.

Decomposition:
- Shared defines file:
  - ysyx_23060251_xlen_bus, mask_bus and ram_bus widths.
  - MEM_BASE constant.
  - 2-bit state encodings: IDLE=0, WAIT=1, RESP=2.
- Sub-module: mem_sram_array, holding the byte-enabled synchronous storage. Inputs: we, idx, wdata, wmask. Output: rdata. Read data is registered at the access edge.
- The FSM, counter and range check stay in mem_resp.

Test Plan:
- LATENCY=1. Store addr 0x8000_0010, data 0x1122334455667788, mask 0xFF. Then load the same address -> resp_rdata_o=0x1122334455667788, err=0; resp_valid_o high exactly 1 cycle after each accept edge.
- Partial store to 0x8000_0010 with mask 0x0F, data 0xAAAAAAAA_BBBBBBBB, then load -> 0x11223344_BBBBBBBB.
- Load from 0x7FFF_FFF8 and from BASE+2^15 -> err=1, rdata=0. A prior store to BASE+2^15 leaves word 0 unchanged.
- LATENCY=4, resp_ready_i held low 3 cycles after resp_valid_o:
  - resp_valid_o rises 4 cycles after accept.
  - rdata/err stay stable while stalled.
  - req_ready_o stays 0 until the cycle after the handshake.
- Assert rst_i low while in WAIT with a pending store to 0x8000_0020, mask 0xFF:
  - resp_valid_o=0 and req_ready_o=1 immediately.
  - A subsequent load of 0x8000_0020 returns the pre-store contents.
- req_valid_i held high with three back-to-back loads, resp_ready_i=1 -> three responses in order, accepts spaced LATENCY+2 cycles apart.
